// File: rtl/crypto1_pkg.sv
// rtl/crypto1_pkg.sv - Crypto1 filter tables, preimage helper and shared types
//
// Purpose: constants and helpers shared by the Fc enumeration path.
//   FA_TAB / FB_TAB : 4-input nibble sub-function truth tables (bit n = f(n))
//   FC_TAB          : 5-input combining function truth table
//   preimage()      : k-th nibble value n (ascending) with tab[n] == b
package crypto1_pkg;

  localparam logic [15:0] FA_TAB = 16'hF22C;
  localparam logic [15:0] FB_TAB = 16'hD938;
  localparam logic [31:0] FC_TAB = 32'hEC57E80A;

  typedef logic [4:0]  fc_in_t;
  typedef logic [19:0] filt_in_t;

  // Tables are balanced, so every (b, k) with k < 8 has a match; the
  // zero default is only reachable for an unbalanced table.
  function automatic logic [3:0] preimage(input logic [15:0] tab,
                                          input logic        b,
                                          input logic [2:0]  k);
    logic [3:0] r;
    int         cnt;
    r   = 4'h0;
    cnt = 0;
    for (int n = 0; n < 16; n++) begin
      if (tab[n] == b) begin
        if (cnt == int'(k)) r = n[3:0];
        cnt++;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/nib_preimage.sv
// rtl/nib_preimage.sv - constant preimage lookup for one nibble sub-function
//
// Purpose: returns the k-th nibble (ascending) whose TAB output equals b.
// Ports:
//   b   in  1  required sub-function output
//   k   in  3  preimage index 0..7
//   nib out 4  matching nibble value
module nib_preimage
  import crypto1_pkg::*;
#(
  parameter logic [15:0] TAB = FA_TAB
) (
  input  logic       b,
  input  logic [2:0] k,
  output logic [3:0] nib
);

  // Both preimage lists fold to constants at elaboration.
  logic [3:0] lut0 [8];
  logic [3:0] lut1 [8];

  for (genvar g = 0; g < 8; g++) begin : g_lut
    assign lut0[g] = preimage(TAB, 1'b0, 3'(g));
    assign lut1[g] = preimage(TAB, 1'b1, 3'(g));
  end

  assign nib = b ? lut1[k] : lut0[k];

endmodule

// File: rtl/fn_enum.sv
// rtl/fn_enum.sv - enumerate all filter-input words matching an Fc input vector
//
// Purpose: for a latched 5-bit Fc input vector, stream all 32768 20-bit words X
// whose nibble sub-function outputs reproduce it, one per cycle.
// Ports:
//   clk       in  1   clock
//   resetn    in  1   asynchronous active-low reset
//   in_valid  in  1   in_fc valid
//   in_ready  out 1   block idle and accepting in_fc
//   in_fc     in  5   target sub-function output vector
//   flush     in  1   synchronous abort of the current enumeration
//   out_valid out 1   out_x holds a candidate
//   out_ready in  1   consumer accepts out_x
//   out_x     out 20  candidate filter-input word
//   out_last  out 1   final candidate for the current in_fc
module fn_enum
  import crypto1_pkg::*;
#(
  parameter logic [15:0] TAB0 = FA_TAB,
  parameter logic [15:0] TAB1 = FB_TAB,
  parameter logic [15:0] TAB2 = FA_TAB,
  parameter logic [15:0] TAB3 = FA_TAB,
  parameter logic [15:0] TAB4 = FB_TAB
) (
  input  logic     clk,
  input  logic     resetn,
  input  logic     in_valid,
  output logic     in_ready,
  input  fc_in_t   in_fc,
  input  logic     flush,
  output logic     out_valid,
  input  logic     out_ready,
  output filt_in_t out_x,
  output logic     out_last
);

  typedef enum logic { IDLE, RUN } state_t;

  state_t      state, state_nx;
  logic [14:0] cnt, cnt_nx;
  fc_in_t      fc_q, fc_nx;
  logic        last;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= 15'd0;
      fc_q  <= 5'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      fc_q  <= fc_nx;
    end
  end

  // out_valid is a decode of the state register, so it is registered and
  // rises the cycle after accept.
  assign last = (cnt == 15'h7FFF);

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    fc_nx     = fc_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        // flush wins over a same-cycle accept
        if (!flush && in_valid) begin
          fc_nx    = in_fc;
          cnt_nx   = 15'd0;
          state_nx = RUN;
        end
      end
      RUN: begin
        out_valid = 1'b1;
        out_last  = last;
        if (flush) begin
          state_nx = IDLE;
        end else if (out_ready) begin
          if (last) state_nx = IDLE;
          else      cnt_nx   = cnt + 15'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Nibble i uses index k_i = cnt[3i+2:3i] and target bit fc[4-i].
  for (genvar i = 0; i < 5; i++) begin : g_nib
    localparam logic [15:0] TAB_I = (i == 0) ? TAB0 :
                                    (i == 1) ? TAB1 :
                                    (i == 2) ? TAB2 :
                                    (i == 3) ? TAB3 : TAB4;
    nib_preimage #(.TAB(TAB_I)) u_nib (
      .b   (fc_q[4-i]),
      .k   (cnt[3*i +: 3]),
      .nib (out_x[4*i +: 4])
    );
  end

endmodule
